prog_loader_ctrl: RTL

- Parametrised program-loader and run controller in front of the single-cycle datapath.
- Replaces hand-sequenced bench tasks: accepts a valid/ready word stream, writes it into instruction or data memory through the datapath's external write ports, then drives the core through clear, run and halt.
- Counts executed cycles and flags bad load addresses.
- Sits between a host/UART/bench stream source and the datapath's test_normal, ext_*, and clr pins.

---
 rtl/prog_loader_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/prog_loader_ctrl.sv
// Program loader and run controller: streams words into IMEM/DMEM, then sequences the core through clear, run and halt.
// Writes land one cycle after acceptance; load_ready is high only in LOAD. PROG_LOADER_WATCHDOG_EN adds wdog_trip and a run-time limit.
module prog_loader_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int RST_CYC    = 2,
  parameter int CYC_W      = 32,
  parameter int WDOG_MAX   = 4096
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              core_halt,
  output logic              test_normal,
  output logic              ext_instr_we,
  output logic [ADDR_W-1:0] ext_instr_addr,
  output logic [DATA_W-1:0] ext_instr_data,
  output logic              ext_data_write_en,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic [DATA_W-1:0] ext_data_data,
  output logic              core_clr,
  output logic              running,
  output logic              done,
  output logic              addr_err,
  output logic [CYC_W-1:0]  cycle_count
`ifdef PROG_LOADER_WATCHDOG_EN
  ,
  output logic              wdog_trip
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CORE_RST = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_HALTED   = 3'd4;

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_DEPTH);

  logic [2:0]       state;
  logic [RC_W-1:0]  rst_cnt;
  logic             beat_acc;
  logic             in_range;
  logic [CYC_W-1:0] cyc_next;

  assign beat_acc = load_valid && (state == S_LOAD);
  assign in_range = load_sel ? ({1'b0, load_addr} < DMEM_LIM)
                             : ({1'b0, load_addr} < IMEM_LIM);
  assign cyc_next = (cycle_count == {CYC_W{1'b1}}) ? cycle_count
                                                   : cycle_count + CYC_W'(1);

  // The core is held in clear from reset until the post-load clear window ends.
  assign load_ready  = (state == S_LOAD);
  assign test_normal = (state == S_IDLE) || (state == S_LOAD);
  assign core_clr    = (state == S_IDLE) || (state == S_LOAD) || (state == S_CORE_RST);
  assign running     = (state == S_RUN);
  assign done        = (state == S_HALTED);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state             <= S_IDLE;
      rst_cnt           <= '0;
      cycle_count       <= '0;
      addr_err          <= 1'b0;
      ext_instr_we      <= 1'b0;
      ext_instr_addr    <= '0;
      ext_instr_data    <= '0;
      ext_data_write_en <= 1'b0;
      ext_data_addr     <= '0;
      ext_data_data     <= '0;
`ifdef PROG_LOADER_WATCHDOG_EN
      wdog_trip         <= 1'b0;
`endif
    end else begin
      ext_instr_we      <= 1'b0;
      ext_data_write_en <= 1'b0;

      // Out-of-range beats are consumed so the stream never stalls on a bad address.
      if (beat_acc) begin
        if (!in_range) begin
          addr_err <= 1'b1;
        end else if (load_sel) begin
          ext_data_write_en <= 1'b1;
          ext_data_addr     <= load_addr;
          ext_data_data     <= load_data;
        end else begin
          ext_instr_we   <= 1'b1;
          ext_instr_addr <= load_addr;
          ext_instr_data <= load_data;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (beat_acc && load_last) begin
            state       <= S_CORE_RST;
            rst_cnt     <= '0;
            cycle_count <= '0;
          end
        end
        S_CORE_RST: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) state <= S_RUN;
          else rst_cnt <= rst_cnt + RC_W'(1);
        end
        S_RUN: begin
          cycle_count <= cyc_next;
          if (core_halt) state <= S_HALTED;
`ifdef PROG_LOADER_WATCHDOG_EN
          else if (cyc_next == CYC_W'(WDOG_MAX)) begin
            state     <= S_HALTED;
            wdog_trip <= 1'b1;
          end
`endif
        end
        S_HALTED: begin
          if (start) begin
            state       <= S_LOAD;
            addr_err    <= 1'b0;
            cycle_count <= '0;
`ifdef PROG_LOADER_WATCHDOG_EN
            wdog_trip   <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
